pht_update_ctrl: RTL and testbench

PHT_UPDATE_CTRL -- requirements
Module: pht_update_ctrl

---
 rtl/bpu_pkg.sv | 24 ++
 rtl/sat_cnt2.sv | 26 ++
 rtl/pht_update_ctrl.sv | 250 +++++++++++++++++++++++++
 tb/tb_pht_update_ctrl.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpu_pkg.sv
// Shared definitions for the branch predictor PHT control slice: default
// table index width, the update-controller state encoding and the values
// each pattern history table is seeded with after reset.
package bpu_pkg;

    // Default PHT index width; each table holds 2^IDX_W_DEF two-bit counters.
    localparam int IDX_W_DEF = 13;

    // Update controller states: table initialisation sweep, idle/lookup,
    // read phase of an update, write-back phase of an update.
    typedef enum logic [1:0] {
        INIT   = 2'd0,
        IDLE   = 2'd1,
        UPD_RD = 2'd2,
        UPD_WR = 2'd3
    } pht_state_t;

    // Seed values: global and local counters start weakly not-taken, the
    // chooser starts weakly preferring the global predictor.
    localparam logic [1:0] G_INIT_VAL = 2'b01;
    localparam logic [1:0] L_INIT_VAL = 2'b01;
    localparam logic [1:0] C_INIT_VAL = 2'b10;

endpackage

// File: rtl/sat_cnt2.sv
// Two-bit saturating counter step: returns val+1 (capped at 3) when up is
// set, otherwise val-1 (floored at 0). Purely combinational.
module sat_cnt2
    import bpu_pkg::*;
(
    input  logic [1:0] val,
    input  logic       up,
    output logic [1:0] nxt
);

    // Step the counter one position toward the requested direction, holding
    // at either end of the range.
    always_comb begin
        nxt = val;
        if (up) begin
            if (val != 2'b11) begin
                nxt = val + 2'd1;
            end
        end else begin
            if (val != 2'b00) begin
                nxt = val - 2'd1;
            end
        end
    end

endmodule

// File: rtl/pht_update_ctrl.sv
// Tournament predictor PHT controller. Seeds the global, local and chooser
// tables after reset, serves single-cycle lookups against the combinational
// table read ports, and performs read-modify-write counter updates on
// branch resolution while maintaining the global history register.
module pht_update_ctrl
    import bpu_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             lk_valid,
    output logic             lk_ready,
    input  logic [31:0]      lk_pc,
    input  logic [IDX_W-1:0] lk_lhist,

    output logic             pred_valid,
    output logic             pred_taken,
    output logic [IDX_W-1:0] pred_ghr,

    input  logic             upd_valid,
    output logic             upd_ready,
    input  logic [31:0]      upd_pc,
    input  logic [IDX_W-1:0] upd_lhist,
    input  logic [IDX_W-1:0] upd_ghr,
    input  logic             upd_taken,

    output logic             g_ren,
    output logic [IDX_W-1:0] g_raddr,
    input  logic [1:0]       g_rdata,
    output logic             g_wen,
    output logic [IDX_W-1:0] g_waddr,
    output logic [1:0]       g_wdata,

    output logic             l_ren,
    output logic [IDX_W-1:0] l_raddr,
    input  logic [1:0]       l_rdata,
    output logic             l_wen,
    output logic [IDX_W-1:0] l_waddr,
    output logic [1:0]       l_wdata,

    output logic             c_ren,
    output logic [IDX_W-1:0] c_raddr,
    input  logic [1:0]       c_rdata,
    output logic             c_wen,
    output logic [IDX_W-1:0] c_waddr,
    output logic [1:0]       c_wdata
);

    pht_state_t       state;
    logic [IDX_W-1:0] init_cnt;
    logic [IDX_W-1:0] ghr;

    logic [IDX_W-1:0] upd_gidx_q;
    logic [IDX_W-1:0] upd_lidx_q;
    logic [IDX_W-1:0] upd_cidx_q;
    logic             upd_taken_q;
    logic [1:0]       g_q;
    logic [1:0]       l_q;
    logic [1:0]       c_q;

    logic             pred_valid_q;
    logic             pred_taken_q;
    logic [IDX_W-1:0] pred_ghr_q;

    logic [IDX_W-1:0] lk_gidx;
    logic [IDX_W-1:0] lk_lidx;
    logic [IDX_W-1:0] lk_cidx;
    logic             in_idle;
    logic             lk_fire;
    logic             pred_taken_d;

    logic [1:0]       g_nxt;
    logic [1:0]       l_nxt;
    logic [1:0]       c_nxt;
    logic             c_up;
    logic             c_needs_write;

    logic             unused_pc_bits;

    // Only the word-index bits of the PCs select table entries.
    assign unused_pc_bits = ^{lk_pc[31:IDX_W+2], lk_pc[1:0],
                              upd_pc[31:IDX_W+2], upd_pc[1:0]};

    // Lookup indices are formed from the live GHR; updates carry their own.
    assign lk_cidx = lk_pc[IDX_W+1:2];
    assign lk_gidx = lk_pc[IDX_W+1:2] ^ ghr;
    assign lk_lidx = lk_lhist;

    // Handshakes: only IDLE accepts work, and a pending update always takes
    // priority over a lookup in the same cycle.
    assign in_idle   = (state == IDLE) && !rst;
    assign upd_ready = in_idle;
    assign lk_ready  = in_idle && !upd_valid;
    assign lk_fire   = lk_ready && lk_valid;

    // Chooser MSB set selects the global prediction, clear selects local.
    assign pred_taken_d = c_rdata[1] ? g_rdata[1] : l_rdata[1];

    // Prediction outputs are registered but forced quiet while in reset.
    assign pred_valid = pred_valid_q && !rst;
    assign pred_taken = pred_taken_q && !rst;
    assign pred_ghr   = rst ? '0 : pred_ghr_q;

    // The chooser trains toward the global predictor when it was right.
    assign c_up          = (g_q[1] == upd_taken_q);
    assign c_needs_write = (g_q[1] != l_q[1]);

    sat_cnt2 u_sat_g (
        .val (g_q),
        .up  (upd_taken_q),
        .nxt (g_nxt)
    );

    sat_cnt2 u_sat_l (
        .val (l_q),
        .up  (upd_taken_q),
        .nxt (l_nxt)
    );

    sat_cnt2 u_sat_c (
        .val (c_q),
        .up  (c_up),
        .nxt (c_nxt)
    );

    // Table port steering: seed writes in INIT, lookup reads in IDLE, update
    // reads in UPD_RD and write-back in UPD_WR; everything idle otherwise.
    always_comb begin
        g_ren   = 1'b0;
        l_ren   = 1'b0;
        c_ren   = 1'b0;
        g_raddr = '0;
        l_raddr = '0;
        c_raddr = '0;
        g_wen   = 1'b0;
        l_wen   = 1'b0;
        c_wen   = 1'b0;
        g_waddr = '0;
        l_waddr = '0;
        c_waddr = '0;
        g_wdata = 2'b00;
        l_wdata = 2'b00;
        c_wdata = 2'b00;
        if (!rst) begin
            case (state)
                INIT: begin
                    g_wen   = 1'b1;
                    l_wen   = 1'b1;
                    c_wen   = 1'b1;
                    g_waddr = init_cnt;
                    l_waddr = init_cnt;
                    c_waddr = init_cnt;
                    g_wdata = G_INIT_VAL;
                    l_wdata = L_INIT_VAL;
                    c_wdata = C_INIT_VAL;
                end
                IDLE: begin
                    if (lk_fire) begin
                        g_ren   = 1'b1;
                        l_ren   = 1'b1;
                        c_ren   = 1'b1;
                        g_raddr = lk_gidx;
                        l_raddr = lk_lidx;
                        c_raddr = lk_cidx;
                    end
                end
                UPD_RD: begin
                    g_ren   = 1'b1;
                    l_ren   = 1'b1;
                    c_ren   = 1'b1;
                    g_raddr = upd_gidx_q;
                    l_raddr = upd_lidx_q;
                    c_raddr = upd_cidx_q;
                end
                UPD_WR: begin
                    g_wen   = 1'b1;
                    l_wen   = 1'b1;
                    c_wen   = c_needs_write;
                    g_waddr = upd_gidx_q;
                    l_waddr = upd_lidx_q;
                    c_waddr = upd_cidx_q;
                    g_wdata = g_nxt;
                    l_wdata = l_nxt;
                    c_wdata = c_nxt;
                end
                default: begin
                end
            endcase
        end
    end

    // Controller state, seed sweep counter, GHR, captured update fields and
    // the registered prediction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= INIT;
            init_cnt     <= '0;
            ghr          <= '0;
            upd_gidx_q   <= '0;
            upd_lidx_q   <= '0;
            upd_cidx_q   <= '0;
            upd_taken_q  <= 1'b0;
            g_q          <= 2'b00;
            l_q          <= 2'b00;
            c_q          <= 2'b00;
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_ghr_q   <= '0;
        end else begin
            pred_valid_q <= lk_fire;
            if (lk_fire) begin
                pred_taken_q <= pred_taken_d;
                pred_ghr_q   <= ghr;
            end
            case (state)
                INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == '1) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (upd_valid) begin
                        upd_cidx_q  <= upd_pc[IDX_W+1:2];
                        upd_gidx_q  <= upd_pc[IDX_W+1:2] ^ upd_ghr;
                        upd_lidx_q  <= upd_lhist;
                        upd_taken_q <= upd_taken;
                        state       <= UPD_RD;
                    end
                end
                UPD_RD: begin
                    g_q   <= g_rdata;
                    l_q   <= l_rdata;
                    c_q   <= c_rdata;
                    state <= UPD_WR;
                end
                UPD_WR: begin
                    ghr   <= {ghr[IDX_W-2:0], upd_taken_q};
                    state <= IDLE;
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pht_update_ctrl.sv
// Self-checking bench for pht_update_ctrl: models the three PHTs as memories
// with combinational reads, and checks the controller against an abstract
// tournament-predictor model kept in plain arrays.
module tb_pht_update_ctrl;

    localparam int IDX_W = 13;
    localparam int DEPTH = 1 << IDX_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             lk_valid;
    logic             lk_ready;
    logic [31:0]      lk_pc;
    logic [IDX_W-1:0] lk_lhist;
    logic             pred_valid;
    logic             pred_taken;
    logic [IDX_W-1:0] pred_ghr;
    logic             upd_valid;
    logic             upd_ready;
    logic [31:0]      upd_pc;
    logic [IDX_W-1:0] upd_lhist;
    logic [IDX_W-1:0] upd_ghr;
    logic             upd_taken;
    logic             g_ren, l_ren, c_ren;
    logic [IDX_W-1:0] g_raddr, l_raddr, c_raddr;
    logic [1:0]       g_rdata, l_rdata, c_rdata;
    logic             g_wen, l_wen, c_wen;
    logic [IDX_W-1:0] g_waddr, l_waddr, c_waddr;
    logic [1:0]       g_wdata, l_wdata, c_wdata;

    // Table memories and write accounting (owned by the memory process).
    logic [1:0] gmem [DEPTH];
    logic [1:0] lmem [DEPTH];
    logic [1:0] cmem [DEPTH];
    int         wcnt_g [DEPTH];
    int         wcnt_l [DEPTH];
    int         wcnt_c [DEPTH];
    int         total_writes = 0;

    // Preload port so the bench can place chosen counter values.
    logic             pre_en = 1'b0;
    logic [IDX_W-1:0] pre_gi, pre_li, pre_ci;
    logic [1:0]       pre_gv, pre_lv, pre_cv;

    // Reference model state.
    int               exp_g [DEPTH];
    int               exp_l [DEPTH];
    int               exp_c [DEPTH];
    logic [IDX_W-1:0] exp_ghr;
    int               base_g [DEPTH];
    int               base_l [DEPTH];
    int               base_c [DEPTH];

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    pht_update_ctrl #(.IDX_W(IDX_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .lk_valid   (lk_valid),
        .lk_ready   (lk_ready),
        .lk_pc      (lk_pc),
        .lk_lhist   (lk_lhist),
        .pred_valid (pred_valid),
        .pred_taken (pred_taken),
        .pred_ghr   (pred_ghr),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_pc     (upd_pc),
        .upd_lhist  (upd_lhist),
        .upd_ghr    (upd_ghr),
        .upd_taken  (upd_taken),
        .g_ren      (g_ren),
        .g_raddr    (g_raddr),
        .g_rdata    (g_rdata),
        .g_wen      (g_wen),
        .g_waddr    (g_waddr),
        .g_wdata    (g_wdata),
        .l_ren      (l_ren),
        .l_raddr    (l_raddr),
        .l_rdata    (l_rdata),
        .l_wen      (l_wen),
        .l_waddr    (l_waddr),
        .l_wdata    (l_wdata),
        .c_ren      (c_ren),
        .c_raddr    (c_raddr),
        .c_rdata    (c_rdata),
        .c_wen      (c_wen),
        .c_waddr    (c_waddr),
        .c_wdata    (c_wdata)
    );

    assign g_rdata = gmem[g_raddr];
    assign l_rdata = lmem[l_raddr];
    assign c_rdata = cmem[c_raddr];

    // Table memories: writes land on the rising edge.
    always @(posedge clk) begin
        if (pre_en) begin
            gmem[pre_gi] <= pre_gv;
            lmem[pre_li] <= pre_lv;
            cmem[pre_ci] <= pre_cv;
        end
        if (g_wen) begin
            gmem[g_waddr]   <= g_wdata;
            wcnt_g[g_waddr] <= wcnt_g[g_waddr] + 1;
        end
        if (l_wen) begin
            lmem[l_waddr]   <= l_wdata;
            wcnt_l[l_waddr] <= wcnt_l[l_waddr] + 1;
        end
        if (c_wen) begin
            cmem[c_waddr]   <= c_wdata;
            wcnt_c[c_waddr] <= wcnt_c[c_waddr] + 1;
        end
        total_writes <= total_writes + (g_wen ? 1 : 0) + (l_wen ? 1 : 0) + (c_wen ? 1 : 0);
    end

    function automatic int sat_step(input int v, input bit up);
        if (up) return (v + 1 > 3) ? 3 : v + 1;
        return (v - 1 < 0) ? 0 : v - 1;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] pc);
        return IDX_W'((pc >> 2) % DEPTH);
    endfunction

    task automatic init_model();
        for (int a = 0; a < DEPTH; a++) begin
            exp_g[a] = 1;
            exp_l[a] = 1;
            exp_c[a] = 2;
        end
        exp_ghr = '0;
    endtask

    task automatic snapshot_counts();
        for (int a = 0; a < DEPTH; a++) begin
            base_g[a] = wcnt_g[a];
            base_l[a] = wcnt_l[a];
            base_c[a] = wcnt_c[a];
        end
    endtask

    // Counts sampled cycles with lk_ready low, bounded.
    task automatic wait_ready(output int zeros);
        zeros = 0;
        while (lk_ready !== 1'b1 && zeros < DEPTH + 100) begin
            zeros++;
            @(negedge clk);
            #1;
        end
    endtask

    // Model of one resolved branch applied to the abstract tables.
    task automatic model_update(input logic [31:0] pc, input logic [IDX_W-1:0] lh,
                                input logic [IDX_W-1:0] gh, input bit tk,
                                output logic [IDX_W-1:0] gi, output logic [IDX_W-1:0] ci);
        int g, l, c;
        bit gtk, ltk;
        ci = word_idx(pc);
        gi = ci ^ gh;
        g = exp_g[gi];
        l = exp_l[lh];
        c = exp_c[ci];
        gtk = (g >= 2);
        ltk = (l >= 2);
        exp_g[gi] = sat_step(g, tk);
        exp_l[lh] = sat_step(l, tk);
        if (gtk != ltk) exp_c[ci] = sat_step(c, gtk == tk);
        exp_ghr = IDX_W'({exp_ghr, tk});
    endtask

    function automatic bit model_pred(input logic [31:0] pc, input logic [IDX_W-1:0] lh);
        logic [IDX_W-1:0] ci;
        ci = word_idx(pc);
        if (exp_c[ci] >= 2) return exp_g[ci ^ exp_ghr] >= 2;
        return exp_l[lh] >= 2;
    endfunction

    task automatic do_lookup(input logic [31:0] pc, input logic [IDX_W-1:0] lh, input string nm);
        bit exp_t;
        exp_t = model_pred(pc, lh);
        @(negedge clk);
        lk_valid = 1'b1; lk_pc = pc; lk_lhist = lh; upd_valid = 1'b0;
        #1;
        checks++;
        if (lk_ready !== 1'b1) $display("[TB] FAIL %s lk_ready got %b want 1", nm, lk_ready);
        else passes++;
        @(negedge clk);
        lk_valid = 1'b0; lk_pc = $urandom; lk_lhist = IDX_W'($urandom);
        #1;
        checks++;
        if ({pred_valid, pred_taken, pred_ghr} !== {1'b1, exp_t, exp_ghr})
            $display("[TB] FAIL %s pred v/t/ghr got %b/%b/%h want 1/%b/%h", nm, pred_valid, pred_taken, pred_ghr, exp_t, exp_ghr);
        else passes++;
        @(negedge clk);
        #1;
        checks++;
        if (pred_valid !== 1'b0) $display("[TB] FAIL %s pred_valid_drop got %b want 0", nm, pred_valid);
        else passes++;
    endtask

    task automatic do_update(input logic [31:0] pc, input logic [IDX_W-1:0] lh,
                             input logic [IDX_W-1:0] gh, input bit tk, input string nm);
        logic [IDX_W-1:0] gi, ci;
        @(negedge clk);
        upd_valid = 1'b1; upd_pc = pc; upd_lhist = lh; upd_ghr = gh; upd_taken = tk; lk_valid = 1'b0;
        #1;
        checks++;
        if (upd_ready !== 1'b1) $display("[TB] FAIL %s upd_ready got %b want 1", nm, upd_ready);
        else passes++;
        @(negedge clk);
        upd_valid = 1'b0; upd_pc = $urandom; upd_lhist = IDX_W'($urandom);
        upd_ghr = IDX_W'($urandom); upd_taken = 1'($urandom);
        #1;
        checks++;
        if ({upd_ready, lk_ready} !== 2'b00) $display("[TB] FAIL %s busy_rd ready got %b want 00", nm, {upd_ready, lk_ready});
        else passes++;
        @(negedge clk);
        #1;
        checks++;
        if ({upd_ready, lk_ready} !== 2'b00) $display("[TB] FAIL %s busy_wr ready got %b want 00", nm, {upd_ready, lk_ready});
        else passes++;
        @(negedge clk);
        #1;
        model_update(pc, lh, gh, tk, gi, ci);
        checks++;
        if ({gmem[gi], lmem[lh], cmem[ci]} !== {2'(exp_g[gi]), 2'(exp_l[lh]), 2'(exp_c[ci])})
            $display("[TB] FAIL %s tables g/l/c got %b/%b/%b want %0d/%0d/%0d", nm, gmem[gi], lmem[lh], cmem[ci], exp_g[gi], exp_l[lh], exp_c[ci]);
        else passes++;
        checks++;
        if (lk_ready !== 1'b1) $display("[TB] FAIL %s back_idle lk_ready got %b want 1", nm, lk_ready);
        else passes++;
    endtask

    task automatic test_reset();
        int zeros, badcnt, baddat;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({pred_valid, pred_taken, pred_ghr, lk_ready, upd_ready, g_ren, l_ren, c_ren, g_wen, l_wen, c_wen} !== 23'd0)
            $display("[TB] FAIL reset_outputs got %b want 0", {pred_valid, pred_taken, pred_ghr, lk_ready, upd_ready, g_ren, l_ren, c_ren, g_wen, l_wen, c_wen});
        else passes++;
        snapshot_counts();
        @(negedge clk);
        rst = 1'b0;
        #1;
        wait_ready(zeros);
        checks++;
        if (zeros !== DEPTH) $display("[TB] FAIL init_length lk_ready low cycles got %0d want %0d", zeros, DEPTH);
        else passes++;
        badcnt = 0;
        baddat = 0;
        for (int a = 0; a < DEPTH; a++) begin
            if (wcnt_g[a] - base_g[a] != 1 || wcnt_l[a] - base_l[a] != 1 || wcnt_c[a] - base_c[a] != 1) badcnt++;
            if (gmem[a] !== 2'b01 || lmem[a] !== 2'b01 || cmem[a] !== 2'b10) baddat++;
        end
        checks++;
        if (badcnt !== 0) $display("[TB] FAIL init_write_count addresses_wrong got %0d want 0", badcnt);
        else passes++;
        checks++;
        if (baddat !== 0) $display("[TB] FAIL init_data addresses_wrong got %0d want 0", baddat);
        else passes++;
        checks++;
        if (lk_ready !== 1'b1) $display("[TB] FAIL init_done lk_ready got %b want 1", lk_ready);
        else passes++;
        init_model();
    endtask

    task automatic test_default_lookup();
        do_lookup(32'h8000_0010, 13'd5, "default_lookup");
        checks++;
        if (pred_ghr !== 13'd0) $display("[TB] FAIL default_ghr got %h want 0", pred_ghr);
        else passes++;
    endtask

    task automatic test_update_taken();
        do_update(32'h8000_0010, 13'd5, 13'd0, 1'b1, "taken_1");
        checks++;
        if ({gmem[4], lmem[5], cmem[4]} !== 6'b10_10_10) $display("[TB] FAIL taken_1_const got %b want 101010", {gmem[4], lmem[5], cmem[4]});
        else passes++;
        do_update(32'h8000_0010, 13'd5, 13'd0, 1'b1, "taken_2");
        checks++;
        if ({gmem[4], lmem[5], cmem[4]} !== 6'b11_11_10) $display("[TB] FAIL taken_2_const got %b want 111110", {gmem[4], lmem[5], cmem[4]});
        else passes++;
        do_lookup(32'h8000_0010, 13'd5, "ghr_after_two");
        checks++;
        if (pred_ghr !== 13'b11) $display("[TB] FAIL ghr_value got %h want 3", pred_ghr);
        else passes++;
    endtask

    task automatic test_chooser();
        @(negedge clk);
        pre_en = 1'b1; pre_gi = 13'd16; pre_li = 13'd7; pre_ci = 13'd16;
        pre_gv = 2'b11; pre_lv = 2'b00; pre_cv = 2'b10;
        @(negedge clk);
        pre_en = 1'b0;
        exp_g[16] = 3; exp_l[7] = 0; exp_c[16] = 2;
        do_update(32'h8000_0040, 13'd7, 13'd0, 1'b0, "chooser_local");
        checks++;
        if ({gmem[16], lmem[7], cmem[16]} !== 6'b10_00_01) $display("[TB] FAIL chooser_const got %b want 100001", {gmem[16], lmem[7], cmem[16]});
        else passes++;
    endtask

    task automatic test_collision();
        logic [31:0] pc;
        logic [IDX_W-1:0] lh, gi, ci;
        bit tk, exp_t;
        int cyc;
        pc = 32'h8000_0000 | ($urandom_range(0, 7) << 2);
        lh = IDX_W'($urandom_range(0, 7));
        tk = 1'($urandom);
        @(negedge clk);
        lk_valid = 1'b1; lk_pc = pc; lk_lhist = lh;
        upd_valid = 1'b1; upd_pc = pc; upd_lhist = lh; upd_ghr = exp_ghr; upd_taken = tk;
        #1;
        checks++;
        if ({upd_ready, lk_ready} !== 2'b10) $display("[TB] FAIL collision_ready upd/lk got %b want 10", {upd_ready, lk_ready});
        else passes++;
        model_update(pc, lh, upd_ghr, tk, gi, ci);
        @(negedge clk);
        upd_valid = 1'b0;
        #1;
        cyc = 1;
        while (lk_ready !== 1'b1 && cyc < 10) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        checks++;
        if (cyc !== 3) $display("[TB] FAIL collision_latency cycles got %0d want 3", cyc);
        else passes++;
        exp_t = model_pred(pc, lh);
        @(negedge clk);
        lk_valid = 1'b0;
        #1;
        checks++;
        if ({pred_valid, pred_taken, pred_ghr} !== {1'b1, exp_t, exp_ghr})
            $display("[TB] FAIL collision_pred v/t/ghr got %b/%b/%h want 1/%b/%h", pred_valid, pred_taken, pred_ghr, exp_t, exp_ghr);
        else passes++;
    endtask

    task automatic test_random();
        logic [31:0] pc;
        logic [IDX_W-1:0] lh, gh;
        for (int i = 0; i < 40; i++) begin
            pc = 32'h8000_0000 | ($urandom_range(0, 7) << 2);
            lh = IDX_W'($urandom_range(0, 7));
            gh = ($urandom_range(0, 1) == 1) ? exp_ghr : IDX_W'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) do_lookup(pc, lh, "rand_lookup");
            else do_update(pc, lh, gh, 1'($urandom), "rand_update");
        end
    endtask

    task automatic test_rst_mid_update();
        int snap, zeros;
        logic [1:0] g0, l0, c0;
        g0 = gmem[9]; l0 = lmem[3]; c0 = cmem[9];
        @(negedge clk);
        upd_valid = 1'b1; upd_pc = 32'h8000_0024; upd_lhist = 13'd3; upd_ghr = 13'd0; upd_taken = ~g0[1];
        lk_valid = 1'b0;
        @(negedge clk);
        snap = total_writes;
        upd_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({g_wen, l_wen, c_wen, g_ren, l_ren, c_ren} !== 6'd0) $display("[TB] FAIL rst_rd_ports got %b want 0", {g_wen, l_wen, c_wen, g_ren, l_ren, c_ren});
        else passes++;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (total_writes !== snap) $display("[TB] FAIL rst_rd_no_write writes got %0d want %0d", total_writes, snap);
        else passes++;
        checks++;
        if ({gmem[9], lmem[3], cmem[9]} !== {g0, l0, c0}) $display("[TB] FAIL rst_rd_tables got %b want %b", {gmem[9], lmem[3], cmem[9]}, {g0, l0, c0});
        else passes++;
        rst = 1'b0;
        #1;
        checks++;
        if ({g_wen, g_waddr} !== {1'b1, 13'd0}) $display("[TB] FAIL rst_restart_addr wen/addr got %b/%0d want 1/0", g_wen, g_waddr);
        else passes++;
        wait_ready(zeros);
        checks++;
        if (zeros !== DEPTH) $display("[TB] FAIL rst_reinit_length got %0d want %0d", zeros, DEPTH);
        else passes++;
        init_model();
        do_lookup(32'h8000_0024, 13'd3, "post_reset_lookup");
    endtask

    initial begin
        rst = 1'b1;
        lk_valid = 1'b0; lk_pc = '0; lk_lhist = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_lhist = '0; upd_ghr = '0; upd_taken = 1'b0;
        pre_gi = '0; pre_li = '0; pre_ci = '0; pre_gv = '0; pre_lv = '0; pre_cv = '0;
        test_reset();
        test_default_lookup();
        test_update_taken();
        test_chooser();
        test_collision();
        test_random();
        test_rst_mid_update();
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
